// File: rtl/parity_frame_gen_chk_if.sv
// Stream bundle for the parity frame unit: input word stream (s_*) and
// output word stream (m_*) with trailer marker and row parity.
// The slave modport is the parity unit's view; master is the environment's.
interface parity_frame_gen_chk_if #(
    parameter int DATA_W = 8
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_par;

    modport slave (
        input  s_valid,
        input  s_data,
        input  m_ready,
        output s_ready,
        output m_valid,
        output m_data,
        output m_last,
        output m_par
    );

    modport master (
        output s_valid,
        output s_data,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  m_data,
        input  m_last,
        input  m_par
    );
endinterface

// File: rtl/parity_frame_gen_chk.sv
// Streaming parity unit. Groups DATA_W-bit words into frames of FRAME_LEN
// words. Generate mode appends a column-parity trailer to each frame; check
// mode verifies the received trailer and reports a per-frame verdict.
// Every output word carries a row-parity bit; even/odd polarity and the
// mode are latched when the first word of a frame is accepted.
module parity_frame_gen_chk #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 4,
    parameter int ERRCNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic                odd,
    parity_frame_gen_chk_if.slave bus,
    output logic                err_valid,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    localparam int CNT_W = $clog2(FRAME_LEN + 2);

    // Counter value while the last data word of a frame is being accepted,
    // and the value that marks "trailer position" (generate: trailer pending,
    // check: next accepted word is the received trailer).
    localparam logic [CNT_W-1:0] CNT_LAST_DATA = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_TRAILER   = CNT_W'(FRAME_LEN);

    localparam logic [0:0] ST_DATA    = 1'b0;
    localparam logic [0:0] ST_TRAILER = 1'b1;

    logic [0:0]          state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [DATA_W-1:0]   acc_q,       acc_d;
    logic                mode_q,      mode_d;
    logic                odd_q,       odd_d;
    logic                m_valid_q,   m_valid_d;
    logic [DATA_W-1:0]   m_data_q,    m_data_d;
    logic                m_last_q,    m_last_d;
    logic                m_par_q,     m_par_d;
    logic                err_valid_q, err_valid_d;
    logic                err_q,       err_d;
    logic [ERRCNT_W-1:0] err_cnt_q,   err_cnt_d;

    logic                s_ready;
    logic                slot_free;
    logic                accept;
    logic                frame_start;
    logic                cur_mode;
    logic                cur_odd;
    logic [DATA_W-1:0]   acc_next;
    logic [DATA_W-1:0]   trailer_word;

    // Handshake and the per-frame view of mode/polarity: the first word of a
    // frame uses the live inputs, later words use the values latched with it.
    always_comb begin
        slot_free    = !m_valid_q || bus.m_ready;
        s_ready      = !rst && (state_q == ST_DATA) && slot_free;
        accept       = bus.s_valid && s_ready;
        frame_start  = (cnt_q == '0);
        cur_mode     = frame_start ? mode : mode_q;
        cur_odd      = frame_start ? odd  : odd_q;
        acc_next     = acc_q ^ bus.s_data;
        trailer_word = acc_q ^ {DATA_W{odd_q}};
    end

    // Next-state logic for the frame sequencer, output register and verdict.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mode_d      = mode_q;
        odd_d       = odd_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        m_par_d     = m_par_q;
        err_valid_d = 1'b0;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;

        if (m_valid_q && bus.m_ready) begin
            m_valid_d = 1'b0;
        end

        if (state_q == ST_DATA) begin
            if (accept) begin
                m_valid_d = 1'b1;
                m_data_d  = bus.s_data;
                m_last_d  = 1'b0;
                m_par_d   = (^bus.s_data) ^ cur_odd;
                if (frame_start) begin
                    mode_d = mode;
                    odd_d  = odd;
                end

                if (!cur_mode) begin
                    acc_d = acc_next;
                    if (cnt_q == CNT_LAST_DATA) begin
                        cnt_d   = CNT_TRAILER;
                        state_d = ST_TRAILER;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    if (cnt_q == CNT_TRAILER) begin
                        m_last_d    = 1'b1;
                        err_valid_d = 1'b1;
                        err_d       = (acc_next != {DATA_W{cur_odd}});
                        if ((acc_next != {DATA_W{cur_odd}}) && (err_cnt_q != '1)) begin
                            err_cnt_d = err_cnt_q + ERRCNT_W'(1);
                        end
                        acc_d = '0;
                        cnt_d = '0;
                    end else begin
                        acc_d = acc_next;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        end else begin
            if (slot_free) begin
                m_valid_d = 1'b1;
                m_data_d  = trailer_word;
                m_last_d  = 1'b1;
                m_par_d   = (^trailer_word) ^ odd_q;
                acc_d     = '0;
                cnt_d     = '0;
                state_d   = ST_DATA;
            end
        end
    end

    // State registers with synchronous reset; reset drops any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_DATA;
            cnt_q       <= '0;
            acc_q       <= '0;
            mode_q      <= 1'b0;
            odd_q       <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            m_par_q     <= 1'b0;
            err_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mode_q      <= mode_d;
            odd_q       <= odd_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            m_par_q     <= m_par_d;
            err_valid_q <= err_valid_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.s_ready  = s_ready;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_data   = m_data_q;
    assign bus.m_last   = m_last_q;
    assign bus.m_par    = m_par_q;
    assign err_valid    = err_valid_q;
    assign err          = err_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_parity_frame_gen_chk.sv
// Directed self-checking bench for parity_frame_gen_chk (DATA_W=8,
// FRAME_LEN=4, narrow error counter so saturation is reachable).
module tb_parity_frame_gen_chk;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       odd;
    logic       err_valid;
    logic       err;
    logic [1:0] err_cnt;

    int compare_count = 0;
    int fail_count    = 0;

    logic [7:0] out_data[$];
    logic       out_last[$];
    logic       out_par[$];
    logic [7:0] exp_data[$];
    logic       exp_last[$];
    logic       exp_par[$];

    logic       err_bit_log[$];
    logic [1:0] err_cnt_log[$];
    logic       err_last_log[$];
    logic       err_mvalid_log[$];
    logic       exp_err_bit[$];
    logic [1:0] exp_err_cnt[$];

    parity_frame_gen_chk_if #(.DATA_W(8)) bus ();

    parity_frame_gen_chk #(
        .DATA_W   (8),
        .FRAME_LEN(4),
        .ERRCNT_W (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .odd      (odd),
        .bus      (bus),
        .err_valid(err_valid),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    // Record every completed output transfer and every verdict pulse.
    always @(negedge clk) begin
        if (!rst && bus.m_valid && bus.m_ready) begin
            out_data.push_back(bus.m_data);
            out_last.push_back(bus.m_last);
            out_par.push_back(bus.m_par);
        end
        if (!rst && err_valid) begin
            err_bit_log.push_back(err);
            err_cnt_log.push_back(err_cnt);
            err_last_log.push_back(bus.m_last);
            err_mvalid_log.push_back(bus.m_valid);
        end
    end

    // Hard stop in case anything stalls beyond every bounded wait.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one word and hold it until accepted (bounded wait).
    task automatic applyStimulus(input logic [7:0] d);
        int wait_cycles = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        @(negedge clk);
        while (!bus.s_ready && wait_cycles < 50) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (!bus.s_ready) begin
            compare_count++;
            fail_count++;
            $display("[TB] FAIL accept_timeout observed=s_ready_low expected=accept data=%0h", d);
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic expectWord(input logic [7:0] d, input logic l, input logic p);
        exp_data.push_back(d);
        exp_last.push_back(l);
        exp_par.push_back(p);
    endtask

    task automatic expectErr(input logic e, input logic [1:0] c);
        exp_err_bit.push_back(e);
        exp_err_cnt.push_back(c);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic compareOutputs(input string tag);
        checkOutput({tag, "_count"}, out_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size(); i++) begin
            if (i < out_data.size()) begin
                checkOutput($sformatf("%s_data%0d", tag, i), out_data[i], exp_data[i]);
                checkOutput($sformatf("%s_last%0d", tag, i), out_last[i], exp_last[i]);
                checkOutput($sformatf("%s_par%0d", tag, i), out_par[i], exp_par[i]);
            end
        end
        out_data.delete(); out_last.delete(); out_par.delete();
        exp_data.delete(); exp_last.delete(); exp_par.delete();
    endtask

    task automatic compareErrs(input string tag);
        checkOutput({tag, "_pulses"}, err_bit_log.size(), exp_err_bit.size());
        for (int i = 0; i < exp_err_bit.size(); i++) begin
            if (i < err_bit_log.size()) begin
                checkOutput($sformatf("%s_err%0d", tag, i), err_bit_log[i], exp_err_bit[i]);
                checkOutput($sformatf("%s_cnt%0d", tag, i), err_cnt_log[i], exp_err_cnt[i]);
                checkOutput($sformatf("%s_mlast%0d", tag, i), err_last_log[i], 1);
                checkOutput($sformatf("%s_mvalid%0d", tag, i), err_mvalid_log[i], 1);
            end
        end
        err_bit_log.delete(); err_cnt_log.delete();
        err_last_log.delete(); err_mvalid_log.delete();
        exp_err_bit.delete(); exp_err_cnt.delete();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_m_valid"}, bus.m_valid, 0);
        checkOutput({tag, "_m_data"}, bus.m_data, 0);
        checkOutput({tag, "_m_last"}, bus.m_last, 0);
        checkOutput({tag, "_m_par"}, bus.m_par, 0);
        checkOutput({tag, "_err_valid"}, err_valid, 0);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_err_cnt"}, err_cnt, 0);
        checkOutput({tag, "_s_ready"}, bus.s_ready, 0);
    endtask

    // Directed sequence of test steps.
    initial begin
        rst         = 1'b1;
        mode        = 1'b0;
        odd         = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;

        settle(3);
        checkResetState("reset");
        rst = 1'b0;
        settle(1);
        checkOutput("idle_s_ready", bus.s_ready, 1);

        // Generate, even parity.
        applyStimulus(8'h01); applyStimulus(8'h02);
        applyStimulus(8'h04); applyStimulus(8'h08);
        settle(4);
        expectWord(8'h01, 0, 1); expectWord(8'h02, 0, 1);
        expectWord(8'h04, 0, 1); expectWord(8'h08, 0, 1);
        expectWord(8'h0F, 1, 0);
        compareOutputs("gen_even");
        compareErrs("gen_even_noverdict");

        // Generate, odd parity.
        odd = 1'b1;
        applyStimulus(8'h01); applyStimulus(8'h02);
        applyStimulus(8'h04); applyStimulus(8'h08);
        settle(4);
        expectWord(8'h01, 0, 0); expectWord(8'h02, 0, 0);
        expectWord(8'h04, 0, 0); expectWord(8'h08, 0, 0);
        expectWord(8'hF0, 1, 1);
        compareOutputs("gen_odd");
        compareErrs("gen_odd_noverdict");
        checkOutput("gen_err_cnt", err_cnt, 0);

        // Check mode: good frame then bad frame.
        odd  = 1'b0;
        mode = 1'b1;
        applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h04);
        applyStimulus(8'h08); applyStimulus(8'h0F);
        applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h04);
        applyStimulus(8'h08); applyStimulus(8'h0E);
        settle(4);
        expectWord(8'h01, 0, 1); expectWord(8'h02, 0, 1); expectWord(8'h04, 0, 1);
        expectWord(8'h08, 0, 1); expectWord(8'h0F, 1, 0);
        expectWord(8'h01, 0, 1); expectWord(8'h02, 0, 1); expectWord(8'h04, 0, 1);
        expectWord(8'h08, 0, 1); expectWord(8'h0E, 1, 1);
        compareOutputs("chk");
        expectErr(0, 2'd0);
        expectErr(1, 2'd1);
        compareErrs("chk_verdict");

        // Generate with downstream stall while the second word is presented.
        mode = 1'b0;
        fork
            begin
                applyStimulus(8'h01); applyStimulus(8'h02);
                applyStimulus(8'h04); applyStimulus(8'h08);
            end
            begin
                int seen = 0;
                for (int i = 0; i < 20 && seen == 0; i++) begin
                    @(posedge clk);
                    #1;
                    if (bus.m_valid && bus.m_data == 8'h02) seen = 1;
                end
                checkOutput("stall_seen_word2", seen, 1);
                bus.m_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    checkOutput($sformatf("stall_hold%0d", i), bus.m_data, 8'h02);
                    checkOutput($sformatf("stall_s_ready%0d", i), bus.s_ready, 0);
                end
                @(posedge clk);
                #1;
                bus.m_ready = 1'b1;
            end
        join
        settle(4);
        expectWord(8'h01, 0, 1); expectWord(8'h02, 0, 1);
        expectWord(8'h04, 0, 1); expectWord(8'h08, 0, 1);
        expectWord(8'h0F, 1, 0);
        compareOutputs("stall");

        // Reset in the middle of a frame.
        applyStimulus(8'h11); applyStimulus(8'h22);
        rst = 1'b1;
        settle(1);
        checkResetState("midreset");
        rst = 1'b0;
        settle(1);
        out_data.delete(); out_last.delete(); out_par.delete();
        applyStimulus(8'h10); applyStimulus(8'h20);
        applyStimulus(8'h40); applyStimulus(8'h80);
        settle(4);
        expectWord(8'h10, 0, 1); expectWord(8'h20, 0, 1);
        expectWord(8'h40, 0, 1); expectWord(8'h80, 0, 1);
        expectWord(8'hF0, 1, 0);
        compareOutputs("post_reset");

        // Mode change mid-frame is ignored until the next frame.
        applyStimulus(8'h01); applyStimulus(8'h02);
        mode = 1'b1;
        applyStimulus(8'h04); applyStimulus(8'h08);
        settle(3);
        applyStimulus(8'h03); applyStimulus(8'h05); applyStimulus(8'h06);
        applyStimulus(8'h00); applyStimulus(8'h00);
        settle(4);
        expectWord(8'h01, 0, 1); expectWord(8'h02, 0, 1);
        expectWord(8'h04, 0, 1); expectWord(8'h08, 0, 1);
        expectWord(8'h0F, 1, 0);
        expectWord(8'h03, 0, 0); expectWord(8'h05, 0, 0); expectWord(8'h06, 0, 0);
        expectWord(8'h00, 0, 0); expectWord(8'h00, 1, 0);
        compareOutputs("mode_toggle");
        expectErr(0, 2'd0);
        compareErrs("mode_toggle_verdict");

        // Check mode with odd polarity, then error counter saturation.
        odd = 1'b1;
        applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
        applyStimulus(8'h00); applyStimulus(8'hFF);
        for (int f = 0; f < 4; f++) begin
            for (int w = 0; w < 5; w++) applyStimulus(8'h00);
        end
        settle(4);
        checkOutput("sat_word_count", out_data.size(), 25);
        checkOutput("sat_good_trailer_par", out_par[4], 1);
        out_data.delete(); out_last.delete(); out_par.delete();
        expectErr(0, 2'd0);
        expectErr(1, 2'd1);
        expectErr(1, 2'd2);
        expectErr(1, 2'd3);
        expectErr(1, 2'd3);
        compareErrs("sat");
        checkOutput("sat_final_cnt", err_cnt, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
